// File: rtl/mem_stage_p.sv
// mem_stage_p: MEM pipeline stage between EX and WB. Resolves jumps, performs
// data-memory loads/stores with an optional wait-state count, stalls upstream
// while an access is in flight and registers every WB-bound value.
module mem_stage_p #(
  parameter int DW          = 8,
  parameter int RW          = 2,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic          wr,
  input  logic          wm,
  input  logic          rm,
  input  logic          neq,
  input  logic          j,
  input  logic          jc,
  input  logic          zero,
  input  logic [DW-1:0] pc_target,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] reg_val,
  input  logic [RW-1:0] rd_ex,
  output logic          stall,
  output logic          branch_taken,
  output logic [DW-1:0] jump_target,
  output logic          wb_valid,
  output logic          wr_wb,
  output logic          rm_wb,
  output logic [RW-1:0] rd_wb,
  output logic [DW-1:0] alu_wb,
  output logic [DW-1:0] data_wb
);

  localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_en;
  logic        done;

  // Instruction captured at the accept edge of a multi-cycle access
  logic [DW-1:0] addr_q, sdat_q, tgt_q;
  logic          wr_q, rm_q, wm_q, take_q;
  logic [RW-1:0] rd_q;

  // Instruction completing this cycle: live EX inputs in IDLE, latched copy in BUSY
  logic [DW-1:0] c_addr, c_sdat, c_tgt;
  logic          c_wr, c_rm, c_wm, c_take;
  logic [RW-1:0] c_rd;

  logic          take_ex;
  logic          in_range;
  logic          is_load;
  logic [AW-1:0] idx;
  logic [DW-1:0] rdata;

  logic [DW-1:0] mem_q [DEPTH];

  assign take_ex  = ex_valid & (j | (jc & (neq ? ~zero : zero)));
  assign stall    = (state_q == BUSY);
  assign in_range = (32'(c_addr) < 32'(DEPTH));
  assign idx      = c_addr[AW-1:0];
  // Both rm and wm high is treated as a plain store
  assign is_load  = c_rm & ~c_wm;
  assign rdata    = in_range ? mem_q[idx] : '0;

  // Next-state logic: accept/complete decision and selection of the completing instruction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
    done    = 1'b0;
    c_addr  = alu_result;
    c_sdat  = reg_val;
    c_tgt   = pc_target;
    c_wr    = wr;
    c_rm    = rm;
    c_wm    = wm;
    c_take  = take_ex;
    c_rd    = rd_ex;
    case (state_q)
      IDLE: begin
        if (ex_valid && (rm || wm) && (WAIT_STATES > 0)) begin
          state_d = BUSY;
          cnt_d   = WS;
          lat_en  = 1'b1;
        end else begin
          done = ex_valid;
        end
      end
      BUSY: begin
        cnt_d  = cnt_q - 4'd1;
        c_addr = addr_q;
        c_sdat = sdat_q;
        c_tgt  = tgt_q;
        c_wr   = wr_q;
        c_rm   = rm_q;
        c_wm   = wm_q;
        c_take = take_q;
        c_rd   = rd_q;
        if (cnt_q == 4'd1) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Data array write, only on the commit edge and never while reset is held
  always_ff @(posedge clock) begin
    if (!reset && done && c_wm && in_range) begin
      mem_q[idx] <= c_sdat;
    end
  end

  // Capture the accepted instruction for the duration of the wait states
  always_ff @(posedge clock) begin
    if (lat_en) begin
      addr_q <= alu_result;
      sdat_q <= reg_val;
      tgt_q  <= pc_target;
      wr_q   <= wr;
      rm_q   <= rm;
      wm_q   <= wm;
      take_q <= take_ex;
      rd_q   <= rd_ex;
    end
  end

  // FSM state, wait counter and WB/branch output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      branch_taken <= 1'b0;
      jump_target  <= '0;
      wb_valid     <= 1'b0;
      wr_wb        <= 1'b0;
      rm_wb        <= 1'b0;
      rd_wb        <= '0;
      alu_wb       <= '0;
      data_wb      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_valid     <= done;
      branch_taken <= done & c_take;
      if (done && c_take) begin
        jump_target <= c_tgt;
      end
      if (done) begin
        wr_wb   <= c_wr;
        rm_wb   <= is_load;
        rd_wb   <= c_rd;
        alu_wb  <= c_addr;
        data_wb <= is_load ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_p.sv
// Testbench for mem_stage_p: three instances (no wait states, three wait
// states, 200-word array) driven by directed steps and random traffic and
// compared each cycle with a transaction-level reference model.
module tb_mem_stage_p;

  typedef struct packed {
    logic       v, wr, wm, rm, neq, j, jc, zero;
    logic [7:0] pc, alu, val;
    logic [1:0] rd;
  } in_t;

  typedef struct packed {
    logic       stall, bt;
    logic [7:0] jt;
    logic       wbv, wr, rm;
    logic [1:0] rd;
    logic [7:0] alu, data;
  } out_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  in_t i0, i3, ib;

  logic       st0, bt0, wv0, wr0, rm0, st3, bt3, wv3, wr3, rm3, stb, btb, wvb, wrb, rmb;
  logic [7:0] jt0, al0, dt0, jt3, al3, dt3, jtb, alb, dtb;
  logic [1:0] rd0, rd3, rdb;
  out_t       o0, o3, ob;

  assign o0 = {st0, bt0, jt0, wv0, wr0, rm0, rd0, al0, dt0};
  assign o3 = {st3, bt3, jt3, wv3, wr3, rm3, rd3, al3, dt3};
  assign ob = {stb, btb, jtb, wvb, wrb, rmb, rdb, alb, dtb};

  mem_stage_p #(.DW(8), .RW(2), .DEPTH(256), .WAIT_STATES(0)) u0 (
    .clock(clock), .reset(reset), .ex_valid(i0.v), .wr(i0.wr), .wm(i0.wm), .rm(i0.rm),
    .neq(i0.neq), .j(i0.j), .jc(i0.jc), .zero(i0.zero), .pc_target(i0.pc),
    .alu_result(i0.alu), .reg_val(i0.val), .rd_ex(i0.rd), .stall(st0), .branch_taken(bt0),
    .jump_target(jt0), .wb_valid(wv0), .wr_wb(wr0), .rm_wb(rm0), .rd_wb(rd0),
    .alu_wb(al0), .data_wb(dt0));

  mem_stage_p #(.DW(8), .RW(2), .DEPTH(256), .WAIT_STATES(3)) u3 (
    .clock(clock), .reset(reset), .ex_valid(i3.v), .wr(i3.wr), .wm(i3.wm), .rm(i3.rm),
    .neq(i3.neq), .j(i3.j), .jc(i3.jc), .zero(i3.zero), .pc_target(i3.pc),
    .alu_result(i3.alu), .reg_val(i3.val), .rd_ex(i3.rd), .stall(st3), .branch_taken(bt3),
    .jump_target(jt3), .wb_valid(wv3), .wr_wb(wr3), .rm_wb(rm3), .rd_wb(rd3),
    .alu_wb(al3), .data_wb(dt3));

  mem_stage_p #(.DW(8), .RW(2), .DEPTH(200), .WAIT_STATES(0)) ub (
    .clock(clock), .reset(reset), .ex_valid(ib.v), .wr(ib.wr), .wm(ib.wm), .rm(ib.rm),
    .neq(ib.neq), .j(ib.j), .jc(ib.jc), .zero(ib.zero), .pc_target(ib.pc),
    .alu_result(ib.alu), .reg_val(ib.val), .rd_ex(ib.rd), .stall(stb), .branch_taken(btb),
    .jump_target(jtb), .wb_valid(wvb), .wr_wb(wrb), .rm_wb(rmb), .rd_wb(rdb),
    .alu_wb(alb), .data_wb(dtb));

  // Reference model state (index 0 = u0, 1 = u3, 2 = ub)
  int         ws_t [3] = '{0, 3, 0};
  int         dep_t[3] = '{256, 256, 200};
  out_t       e    [3];
  int         rem  [3];
  in_t        pend [3];
  logic [7:0] mm   [3][256];
  bit         wrt  [3][256];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic take_of(input in_t x);
    return x.j | (x.jc & (x.neq ? ~x.zero : x.zero));
  endfunction

  task automatic commit(input int k, input in_t x);
    logic ld;
    ld         = x.rm & ~x.wm;
    e[k].stall = 1'b0;
    e[k].wbv   = 1'b1;
    e[k].bt    = take_of(x);
    if (e[k].bt) e[k].jt = x.pc;
    e[k].wr    = x.wr;
    e[k].rm    = ld;
    e[k].rd    = x.rd;
    e[k].alu   = x.alu;
    e[k].data  = (ld && int'(x.alu) < dep_t[k]) ? mm[k][x.alu] : 8'h00;
    if (x.wm && int'(x.alu) < dep_t[k]) begin
      mm[k][x.alu]  = x.val;
      wrt[k][x.alu] = 1'b1;
    end
  endtask

  task automatic model_edge(input int k, input in_t x);
    if (rem[k] > 0) begin
      rem[k]--;
      if (rem[k] == 0) commit(k, pend[k]);
      else begin e[k].stall = 1'b1; e[k].wbv = 1'b0; e[k].bt = 1'b0; end
    end else if (x.v && (x.rm || x.wm) && ws_t[k] > 0) begin
      pend[k] = x;
      rem[k]  = ws_t[k];
      e[k].stall = 1'b1; e[k].wbv = 1'b0; e[k].bt = 1'b0;
    end else if (x.v) begin
      commit(k, x);
    end else begin
      e[k].stall = 1'b0; e[k].wbv = 1'b0; e[k].bt = 1'b0;
    end
  endtask

  task automatic rst_model();
    for (int k = 0; k < 3; k++) begin
      e[k]   = '0;
      rem[k] = 0;
    end
  endtask

  function automatic out_t obs_of(input int k);
    case (k)
      0:       return o0;
      1:       return o3;
      default: return ob;
    endcase
  endfunction

  // One clock: advance the model with the inputs presented at the edge, then compare all instances
  task automatic cyc(input string tag);
    in_t x[3];
    x[0] = i0; x[1] = i3; x[2] = ib;
    @(posedge clock);
    #1;
    if (reset) rst_model();
    else for (int k = 0; k < 3; k++) model_edge(k, x[k]);
    for (int k = 0; k < 3; k++) chk($sformatf("%s/u%0d", tag, k), 32'(obs_of(k)), 32'(e[k]));
  endtask

  function automatic in_t st(input logic [7:0] a, input logic [7:0] d);
    in_t x; x = '0; x.v = 1'b1; x.wm = 1'b1; x.alu = a; x.val = d; return x;
  endfunction

  function automatic in_t ld(input logic [7:0] a, input logic [1:0] r);
    in_t x; x = '0; x.v = 1'b1; x.rm = 1'b1; x.wr = 1'b1; x.alu = a; x.rd = r; return x;
  endfunction

  function automatic in_t jmp(input logic jj, input logic c, input logic n, input logic z,
                              input logic [7:0] pc);
    in_t x; x = '0; x.v = 1'b1; x.j = jj; x.jc = c; x.neq = n; x.zero = z; x.pc = pc; return x;
  endfunction

  function automatic in_t rnd(input int k);
    in_t x;
    x.v    = ($urandom_range(0, 3) != 0);
    x.wr   = 1'($urandom); x.wm = 1'($urandom); x.rm = 1'($urandom);
    x.neq  = 1'($urandom); x.j  = 1'($urandom); x.jc = 1'($urandom); x.zero = 1'($urandom);
    x.pc   = 8'($urandom);
    x.alu  = 8'((k == 2) ? $urandom_range(190, 215) : $urandom_range(0, 31));
    x.val  = 8'($urandom);
    x.rd   = 2'($urandom);
    // Never load a word that has not been written yet
    if (x.rm && !x.wm && int'(x.alu) < dep_t[k] && !wrt[k][x.alu]) x.rm = 1'b0;
    return x;
  endfunction

  // Multi-cycle access on the wait-state instance; checks the number of stall cycles
  task automatic mem3(input in_t x, input string tag);
    int n;
    i3 = x;
    cyc({tag, "_acc"});
    n = 0;
    while (o3.stall && n < 10) begin
      i3 = rnd(1);
      cyc(tag);
      n++;
    end
    i3 = '0;
    chk({tag, "_stallcyc"}, 32'(n), 32'd3);
  endtask

  initial begin
    i0 = '0; i3 = '0; ib = '0;
    rst_model();

    // Reset with random inputs
    i0 = rnd(0); i3 = rnd(1); ib = rnd(2);
    cyc("reset");
    cyc("reset");
    chk("rst_u0_zero", 32'(o0), 32'd0);
    chk("rst_u3_zero", 32'(o3), 32'd0);
    reset = 1'b0;
    i0 = '0; i3 = '0; ib = '0;
    cyc("idle");

    // Array survives reset
    i0 = st(8'd3, 8'h5A);
    cyc("st3");
    i0 = '0;
    reset = 1'b1;
    #1;
    rst_model();
    chk("rst_async_u0", 32'(o0), 32'd0);
    cyc("rst_hold");
    reset = 1'b0;
    i0 = ld(8'd3, 2'd1);
    cyc("ld3");
    chk("ld_after_rst", 32'(o0.data), 32'h5A);

    // Jumps, no wait states
    i0 = jmp(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
    cyc("jc_eq");
    chk("jc_eq_bt", 32'(o0.bt), 32'd1);
    chk("jc_eq_jt", 32'(o0.jt), 32'h40);
    i0 = '0;
    cyc("jc_idle");
    chk("bt_pulse", 32'(o0.bt), 32'd0);
    chk("jt_hold", 32'(o0.jt), 32'h40);
    i0 = jmp(1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
    cyc("jc_nt");
    chk("jc_nt_bt", 32'(o0.bt), 32'd0);
    i0 = jmp(1'b0, 1'b1, 1'b1, 1'b0, 8'h22);
    cyc("jc_neq");
    chk("jc_neq_bt", 32'(o0.bt), 32'd1);
    chk("jc_neq_jt", 32'(o0.jt), 32'h22);
    i0 = jmp(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    i0.v = 1'b0;
    cyc("j_inval");
    chk("j_inval_bt", 32'(o0.bt), 32'd0);
    chk("j_inval_wbv", 32'(o0.wbv), 32'd0);

    // rm and wm together behave as a store
    i0 = st(8'd7, 8'h33);
    i0.rm = 1'b1;
    cyc("rmwm");
    chk("rmwm_rm", 32'(o0.rm), 32'd0);
    chk("rmwm_data", 32'(o0.data), 32'd0);
    i0 = ld(8'd7, 2'd3);
    cyc("ld7");
    chk("ld7_data", 32'(o0.data), 32'h33);
    i0 = '0;

    // Wait states
    i3 = jmp(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    cyc("ws_jmp");
    chk("ws_jmp_bt", 32'(o3.bt), 32'd1);
    chk("ws_jmp_stall", 32'(o3.stall), 32'd0);
    i3 = '0;
    mem3(st(8'd5, 8'h3C), "pre5");
    mem3(st(8'h10, 8'hA5), "st10");
    chk("st10_wbv", 32'(o3.wbv), 32'd1);
    cyc("st10_after");
    chk("st10_wbv_pulse", 32'(o3.wbv), 32'd0);
    mem3(ld(8'h10, 2'd2), "ld10");
    chk("ld10_data", 32'(o3.data), 32'hA5);
    chk("ld10_rm", 32'(o3.rm), 32'd1);
    chk("ld10_rd", 32'(o3.rd), 32'd2);
    chk("ld10_wbv", 32'(o3.wbv), 32'd1);
    cyc("ld10_after");
    chk("ld10_wbv_pulse", 32'(o3.wbv), 32'd0);

    // Abort: reset on the second stall cycle discards the pending store
    i3 = st(8'd5, 8'h77);
    cyc("abort_acc");
    i3 = '0;
    cyc("abort_busy");
    #2;
    reset = 1'b1;
    #1;
    rst_model();
    chk("abort_stall", 32'(o3.stall), 32'd0);
    chk("abort_u3_zero", 32'(o3), 32'd0);
    #2;
    reset = 1'b0;
    cyc("post_abort");
    mem3(ld(8'd5, 2'd1), "ld5");
    chk("abort_ld5", 32'(o3.data), 32'h3C);

    // Boundary on the 200-word instance
    ib = st(8'd210, 8'h11);
    cyc("st210");
    ib = ld(8'd210, 2'd1);
    cyc("ld210");
    chk("ld210_data", 32'(ob.data), 32'd0);
    chk("ld210_wbv", 32'(ob.wbv), 32'd1);
    ib = st(8'd199, 8'h6B);
    cyc("st199");
    ib = ld(8'd199, 2'd0);
    cyc("ld199");
    chk("ld199_data", 32'(ob.data), 32'h6B);
    ib = '0;

    // Random traffic on all instances
    for (int n = 0; n < 300; n++) begin
      i0 = rnd(0); i3 = rnd(1); ib = rnd(2);
      cyc("rand");
    end
    i0 = '0; i3 = '0; ib = '0;
    for (int n = 0; n < 4; n++) cyc("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
